char_text_buf: RTL and testbench

Parametrised, writable character-cell buffer for the on-screen text layer. It replaces the fixed 16x16 character ROM with a register-based COLS x ROWS grid of character codes. At reset the grid loads a static text image from a shared package. At run time single cells can be overwritten, and binary values (mine count, timer, level) can be rendered as right-aligned decimal fields. It sits between the game controller and the character-drawing pipeline, which reads one cell per pixel clock.

---
 rtl/char_text_pkg.sv | 46 ++++
 rtl/char_text_buf_bin2bcd_seq.sv | 59 +++++
 rtl/char_text_buf.sv | 166 ++++++++++++++++
 tb/tb_char_text_buf.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/char_text_pkg.sv
// Shared definitions for the on-screen text layer: default grid geometry, the
// power-up menu text image, character constants and the number-engine states.
package char_text_pkg;

  localparam int unsigned TEXT_COLS   = 16;
  localparam int unsigned TEXT_ROWS   = 16;
  localparam int unsigned TEXT_CODE_W = 7;
  localparam int unsigned TEXT_CW     = $clog2(TEXT_COLS);
  localparam int unsigned TEXT_RW     = $clog2(TEXT_ROWS);

  localparam logic [TEXT_CODE_W-1:0] CHAR_SPACE = 7'h20;
  localparam logic [TEXT_CODE_W-1:0] CHAR_ZERO  = 7'h30;
  localparam logic [TEXT_CODE_W-1:0] CHAR_NINE  = 7'h39;

  typedef enum logic [1:0] {StIdle, StConv, StWrite, StDone} num_state_e;

  typedef logic [TEXT_ROWS-1:0][TEXT_COLS-1:0][TEXT_CODE_W-1:0] text_t;

  // Menu image; empty cells hold code 0 so the drawer renders nothing there.
  function automatic text_t build_text();
    text_t t;
    t = '0;
    // "AUTHOR"
    t[0][1] = 7'h41; t[0][2] = 7'h55; t[0][3] = 7'h54;
    t[0][4] = 7'h48; t[0][5] = 7'h4F; t[0][6] = 7'h52;
    // "J.DOE"
    t[2][1] = 7'h4A; t[2][2] = 7'h2E; t[2][3] = 7'h44;
    t[2][4] = 7'h4F; t[2][5] = 7'h45;
    // "LEVEL"
    t[5][1] = 7'h4C; t[5][2] = 7'h45; t[5][3] = 7'h56;
    t[5][4] = 7'h45; t[5][5] = 7'h4C;
    // "BTN"
    t[8][1] = 7'h42; t[8][2] = 7'h54; t[8][3] = 7'h4E;
    return t;
  endfunction

  localparam text_t DEFAULT_TEXT = build_text();

  function automatic logic [TEXT_CODE_W-1:0] default_cell(input int row, input int col);
    if (row < 0 || col < 0 || row >= int'(TEXT_ROWS) || col >= int'(TEXT_COLS)) begin
      return '0;
    end
    return DEFAULT_TEXT[row[TEXT_RW-1:0]][col[TEXT_CW-1:0]];
  endfunction

endpackage

// File: rtl/char_text_buf_bin2bcd_seq.sv
// Sequential double-dabble: one input bit per cycle, VAL_W cycles per value.
// Values beyond DIGITS decimal digits raise sat for the consumer to clamp.
module bin2bcd_seq #(
  parameter int unsigned VAL_W  = 10,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [VAL_W-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  sat
);

  localparam int unsigned CNT_W   = $clog2(VAL_W) + 1;
  localparam int unsigned MAX_VAL = 10 ** DIGITS - 1;

  logic [VAL_W-1:0]    bin_q;
  logic [DIGITS*4-1:0] bcd_q, bcd_adj;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q, sat_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // High in the cycle whose closing edge performs the final shift.
  assign done = busy_q && (cnt_q == CNT_W'(VAL_W - 1));
  assign busy = busy_q;
  assign bcd  = bcd_q;
  assign sat  = sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (start) begin
      bin_q  <= value;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      sat_q  <= 32'(value) > MAX_VAL;
    end else if (busy_q) begin
      bcd_q <= {bcd_adj[DIGITS*4-2:0], bin_q[VAL_W-1]};
      bin_q <= bin_q << 1;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/char_text_buf.sv
// Writable character-cell grid for the text layer, with a single-cell write
// port and a number engine that renders right-aligned decimal fields.
module char_text_buf
  import char_text_pkg::*;
#(
  parameter int unsigned COLS   = TEXT_COLS,
  parameter int unsigned ROWS   = TEXT_ROWS,
  parameter int unsigned CODE_W = TEXT_CODE_W,
  parameter int unsigned DIGITS = 3,
  parameter int unsigned VAL_W  = 10,
  localparam int unsigned CW    = $clog2(COLS),
  localparam int unsigned RW    = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CW-1:0]     rd_col,
  input  logic [RW-1:0]     rd_row,
  output logic [CODE_W-1:0] char_code,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CW-1:0]     wr_col,
  input  logic [RW-1:0]     wr_row,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              num_valid,
  output logic              num_ready,
  input  logic [CW-1:0]     num_col,
  input  logic [RW-1:0]     num_row,
  input  logic [VAL_W-1:0]  num_value,
  input  logic              num_lzs,
  output logic              num_done
);

  localparam int unsigned IDX_W = $clog2(DIGITS + 1);

  logic [CODE_W-1:0] grid_q [ROWS][COLS];
  logic [CODE_W-1:0] char_code_q;

  num_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             lead_q, lead_d;
  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;

  logic                conv_start, conv_busy, conv_done, conv_sat;
  logic [DIGITS*4-1:0] conv_bcd;

  logic [3:0]        digit;
  logic              is_last, blank, eng_we, port_we;
  logic [CW:0]       col_sum;
  logic [CODE_W-1:0] eng_code;

  bin2bcd_seq #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .value (num_value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .sat   (conv_sat)
  );

  always_comb begin
    digit = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) digit = conv_bcd[(int'(DIGITS) - 1 - i)*4 +: 4];
    end
    if (conv_sat) digit = 4'd9;
  end

  assign is_last  = (idx_q == IDX_W'(DIGITS - 1));
  assign blank    = lead_q && (digit == 4'd0) && !is_last;
  assign eng_code = blank ? CODE_W'(CHAR_SPACE) : CODE_W'(CHAR_ZERO) + CODE_W'(digit);
  assign col_sum  = {1'b0, col_q} + (CW+1)'(idx_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lead_d     = lead_q;
    num_ready  = 1'b0;
    num_done   = 1'b0;
    wr_ready   = 1'b1;
    eng_we     = 1'b0;
    conv_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        num_ready = 1'b1;
        if (num_valid) begin
          conv_start = 1'b1;
          lead_d     = num_lzs;
          state_d    = StConv;
        end
      end
      StConv: begin
        if (conv_done || !conv_busy) begin
          idx_d   = '0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        wr_ready = 1'b0;
        // Columns past the edge are skipped rather than wrapped into the next row.
        eng_we   = (col_sum < (CW+1)'(COLS)) && ({1'b0, row_q} < (RW+1)'(ROWS));
        lead_d   = blank;
        if (is_last) state_d = StDone;
        else         idx_d   = idx_q + 1'b1;
      end
      StDone: begin
        num_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign port_we = wr_valid && wr_ready &&
                   ({1'b0, wr_col} < (CW+1)'(COLS)) && ({1'b0, wr_row} < (RW+1)'(ROWS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      lead_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lead_q  <= lead_d;
      if (conv_start) begin
        col_q <= num_col;
        row_q <= num_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        for (int c = 0; c < int'(COLS); c++) begin
          grid_q[r][c] <= CODE_W'(default_cell(r, c));
        end
      end
    end else if (eng_we) begin
      grid_q[row_q][col_sum[CW-1:0]] <= eng_code;
    end else if (port_we) begin
      grid_q[wr_row][wr_col] <= wr_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_code_q <= '0;
    end else if (({1'b0, rd_col} < (CW+1)'(COLS)) && ({1'b0, rd_row} < (RW+1)'(ROWS))) begin
      char_code_q <= grid_q[rd_row][rd_col];
    end else begin
      char_code_q <= '0;
    end
  end

  assign char_code = char_code_q;

endmodule

// File: tb/tb_char_text_buf.sv
// Self-checking bench for char_text_buf: reads go through an expectation queue,
// number-engine timing and handshakes are checked against cycle counts.
module tb_char_text_buf;
  import char_text_pkg::*;

  localparam int COLS = 16, ROWS = 16, CODE_W = 7, DIGITS = 3, VAL_W = 10;
  localparam int NUM_LAT = VAL_W + DIGITS + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        rd_col = '0, wr_col = '0, num_col = '0;
  logic [3:0]        rd_row = '0, wr_row = '0, num_row = '0;
  logic [CODE_W-1:0] char_code, wr_code = '0;
  logic              wr_valid = 1'b0, wr_ready;
  logic              num_valid = 1'b0, num_ready, num_lzs = 1'b0, num_done;
  logic [VAL_W-1:0]  num_value = '0;

  typedef struct {
    string             tag;
    logic [CODE_W-1:0] code;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  char_text_buf #(
    .COLS(COLS), .ROWS(ROWS), .CODE_W(CODE_W), .DIGITS(DIGITS), .VAL_W(VAL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_col(rd_col), .rd_row(rd_row), .char_code(char_code),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row),
    .wr_code(wr_code), .num_valid(num_valid), .num_ready(num_ready), .num_col(num_col),
    .num_row(num_row), .num_value(num_value), .num_lzs(num_lzs), .num_done(num_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, 32'(char_code), 32'(e.code));
    end
  endtask

  task automatic read_cell(input int col, input int row, input logic [7:0] code,
                           input string tag);
    exp_t e;
    @(negedge clk);
    rd_col = 4'(col);
    rd_row = 4'(row);
    e.tag  = tag;
    e.code = code[CODE_W-1:0];
    exp_q.push_back(e);
    @(posedge clk);
    #1 pop_compare();
  endtask

  task automatic start_num(input int col, input int row, input int val, input logic lzs);
    @(negedge clk);
    num_col   = 4'(col);
    num_row   = 4'(row);
    num_value = VAL_W'(val);
    num_lzs   = lzs;
    num_valid = 1'b1;
    check("start_ready", 32'(num_ready), 32'd1);
    @(posedge clk);
    #1 num_valid = 1'b0;
  endtask

  // Cycles are labelled by the edge that closes them, acceptance edge being 0.
  task automatic wait_done(output int lat, output int wr_low);
    lat    = -1;
    wr_low = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!wr_ready) wr_low++;
      if (num_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_num(input int col, input int row, input int val, input logic lzs,
                         input string tag);
    int lat, wr_low;
    start_num(col, row, val, lzs);
    wait_done(lat, wr_low);
    check({tag, "_latency"}, 32'(lat), 32'(NUM_LAT));
    check({tag, "_wr_low"}, 32'(wr_low), 32'(DIGITS));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int k, stall, pulses;
    logic [7:0] author [6];
    author = '{8'h41, 8'h55, 8'h54, 8'h48, 8'h4F, 8'h52};

    repeat (3) @(negedge clk);
    check("rst_char_code", 32'(char_code), 32'd0);
    check("rst_num_done", 32'(num_done), 32'd0);
    check("rst_num_ready", 32'(num_ready), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) read_cell(i + 1, 0, author[i], $sformatf("author_%0d", i));
    read_cell(15, 15, 8'h00, "corner_15_15");
    read_cell(3, 5, 8'h56, "level_v_default");

    // Same-edge read and write: old value out, new value on the next read.
    @(negedge clk);
    wr_valid = 1'b1; wr_col = 4'd3; wr_row = 4'd5; wr_code = 7'h58;
    rd_col = 4'd3; rd_row = 4'd5;
    exp_q.push_back('{tag: "same_edge_old", code: 7'h56});
    @(posedge clk);
    #1 pop_compare();
    wr_valid = 1'b0;
    read_cell(3, 5, 8'h58, "write_x");

    run_num(10, 5, 42, 1'b1, "n42");
    read_cell(10, 5, 8'h20, "n42_d0");
    read_cell(11, 5, 8'h34, "n42_d1");
    read_cell(12, 5, 8'h32, "n42_d2");
    read_cell(13, 5, 8'h00, "n42_after");

    run_num(10, 6, 0, 1'b1, "z_lzs");
    read_cell(10, 6, 8'h20, "z_lzs_d0");
    read_cell(11, 6, 8'h20, "z_lzs_d1");
    read_cell(12, 6, 8'h30, "z_lzs_d2");

    run_num(10, 7, 0, 1'b0, "z_nolzs");
    read_cell(10, 7, 8'h30, "z_nolzs_d0");
    read_cell(11, 7, 8'h30, "z_nolzs_d1");
    read_cell(12, 7, 8'h30, "z_nolzs_d2");

    run_num(4, 9, 1023, 1'b1, "sat");
    read_cell(4, 9, 8'h39, "sat_d0");
    read_cell(5, 9, 8'h39, "sat_d1");
    read_cell(6, 9, 8'h39, "sat_d2");

    run_num(4, 10, 307, 1'b1, "n307");
    read_cell(4, 10, 8'h33, "n307_d0");
    read_cell(5, 10, 8'h30, "n307_d1");
    read_cell(6, 10, 8'h37, "n307_d2");

    run_num(COLS - 2, 10, 42, 1'b0, "edge");
    read_cell(14, 10, 8'h30, "edge_d0");
    read_cell(15, 10, 8'h34, "edge_d1");
    read_cell(0, 11, 8'h00, "edge_no_wrap");

    // Port write during CONV goes through; during WRITE it stalls.
    start_num(0, 12, 5, 1'b1);
    k = 0;
    repeat (3) begin @(negedge clk); k++; end
    check("conv_wr_ready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1; wr_col = 4'd8; wr_row = 4'd12; wr_code = 7'h59;
    @(negedge clk); k++;
    wr_valid = 1'b0;
    while (k < VAL_W + 1) begin @(negedge clk); k++; end
    wr_valid = 1'b1; wr_col = 4'd9; wr_code = 7'h5A;
    stall = 0;
    while (!wr_ready && stall < 20) begin @(negedge clk); k++; stall++; end
    check("write_stall", 32'(stall), 32'(DIGITS));
    check("stall_done_cycle", 32'(k), 32'(NUM_LAT));
    check("stall_done_pulse", 32'(num_done), 32'd1);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    check("ready_after_done", 32'(num_ready), 32'd1);
    read_cell(8, 12, 8'h59, "conv_write");
    read_cell(9, 12, 8'h5A, "stalled_write");
    read_cell(0, 12, 8'h20, "n5_d0");
    read_cell(1, 12, 8'h20, "n5_d1");
    read_cell(2, 12, 8'h35, "n5_d2");

    // Reset in the middle of WRITE.
    start_num(1, 0, 42, 1'b0);
    repeat (VAL_W + 2) @(negedge clk);
    check("mid_write_state", 32'(wr_ready), 32'd0);
    rst_n = 1'b0;
    pulses = 0;
    #1;
    check("rst_mid_ready", 32'(num_ready), 32'd1);
    check("rst_mid_wr_ready", 32'(wr_ready), 32'd1);
    repeat (3) begin @(negedge clk); if (num_done) pulses++; end
    rst_n = 1'b1;
    repeat (20) begin @(negedge clk); if (num_done) pulses++; end
    check("rst_mid_no_done", 32'(pulses), 32'd0);
    for (int i = 0; i < 6; i++) read_cell(i + 1, 0, author[i], $sformatf("reload_%0d", i));
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        read_cell(c, r, 8'(default_cell(r, c)), $sformatf("reload_grid_%0d_%0d", c, r));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
